ultra_timebase: RTL and testbench

ULTRA_TIMEBASE -- requirements
Module: ultra_timebase

---
 rtl/ultra_pkg.sv | 17 +
 rtl/tick_div.sv | 26 ++
 rtl/ultra_timebase.sv | 147 ++++++++++++++
 tb/tb_ultra_timebase.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ultra_pkg.sv
// Shared FSM state type and default timing constants for the ultrasonic timebase.
package ultra_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StListen
  } state_e;

  localparam int unsigned DefCarrierDiv  = 2500;
  localparam int unsigned DefBurstPulses = 8;
  localparam int unsigned DefFrameCycles = 3_000_000;
  localparam int unsigned DefScanDiv     = 100_000;
  localparam int unsigned DefCmDiv       = 5882;
  localparam int unsigned DefCmInc       = 730144;

endpackage

// File: rtl/tick_div.sv
// Integer clock-enable divider: one-cycle strobe every DIV cycles, restartable by a sync clear.
module tick_div #(
  parameter int unsigned DIV = 2
) (
  input  logic system_clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] Last = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge system_clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (cnt_q == Last);
      cnt_q <= (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ultra_timebase.sv
// Ultrasonic ranging timebase: burst/listen frame FSM, carrier gating, scan and cm tick strobes.
// Define ULTRA_FRAC_CM_EN to derive tick_cm from a 32-bit phase accumulator instead of CM_DIV.
module ultra_timebase
  import ultra_pkg::*;
#(
  parameter int unsigned CARRIER_DIV  = DefCarrierDiv,
  parameter int unsigned BURST_PULSES = DefBurstPulses,
  parameter int unsigned FRAME_CYCLES = DefFrameCycles,
  parameter int unsigned SCAN_DIV     = DefScanDiv,
  parameter int unsigned CM_DIV       = DefCmDiv,
  parameter int unsigned CM_INC       = DefCmInc
) (
  input  logic system_clk,
  input  logic reset,
  input  logic mode,
  input  logic trig,
  input  logic abort,
  output logic stimulus,
  output logic burst_active,
  output logic listening,
  output logic frame_start,
  output logic frame_done,
  output logic tick_scan,
  output logic tick_cm
);

  localparam int unsigned BurstLen = CARRIER_DIV * BURST_PULSES;
  localparam int unsigned CarW     = $clog2(CARRIER_DIV);
  localparam int unsigned BurW     = $clog2(BurstLen);
  localparam int unsigned FrmW     = $clog2(FRAME_CYCLES);

  localparam logic [CarW-1:0] CarLast = CarW'(CARRIER_DIV - 1);
  localparam logic [CarW-1:0] CarHalf = CarW'(CARRIER_DIV / 2);
  localparam logic [BurW-1:0] BurLast = BurW'(BurstLen - 1);
  localparam logic [FrmW-1:0] FrmLast = FrmW'(FRAME_CYCLES - 1);
  localparam logic [FrmW-1:0] FrmPen  = FrmW'(FRAME_CYCLES - 2);

  state_e          state_q;
  logic [CarW-1:0] carrier_q;
  logic [BurW-1:0] burst_cnt_q;
  logic [FrmW-1:0] frame_cnt_q;

  logic            frame_end;
  logic            start_frame;
  logic            to_idle;
  logic            cm_clear;
  logic [CarW-1:0] carrier_nxt;

  assign frame_end   = (state_q == StListen) && (frame_cnt_q == FrmLast);
  // Abort dominates; mode is only looked at in IDLE and on the last frame cycle.
  assign start_frame = !abort && (((state_q == StIdle) && (mode || trig)) || (frame_end && mode));
  assign to_idle     = abort || ((state_q == StIdle) && !start_frame) || (frame_end && !mode);
  assign cm_clear    = start_frame || to_idle;
  assign carrier_nxt = (carrier_q == CarLast) ? '0 : carrier_q + 1'b1;

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state_q      <= StIdle;
      carrier_q    <= '0;
      burst_cnt_q  <= '0;
      frame_cnt_q  <= '0;
      stimulus     <= 1'b0;
      burst_active <= 1'b0;
      listening    <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (start_frame) begin
        state_q      <= StBurst;
        carrier_q    <= '0;
        burst_cnt_q  <= '0;
        frame_cnt_q  <= '0;
        stimulus     <= 1'b1;
        burst_active <= 1'b1;
        listening    <= 1'b0;
        frame_start  <= 1'b1;
      end else if (to_idle) begin
        state_q      <= StIdle;
        carrier_q    <= '0;
        burst_cnt_q  <= '0;
        frame_cnt_q  <= '0;
        stimulus     <= 1'b0;
        burst_active <= 1'b0;
        listening    <= 1'b0;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
        frame_done  <= (frame_cnt_q == FrmPen);
        if (state_q == StBurst) begin
          if (burst_cnt_q == BurLast) begin
            state_q      <= StListen;
            stimulus     <= 1'b0;
            burst_active <= 1'b0;
            listening    <= 1'b1;
          end else begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
            carrier_q   <= carrier_nxt;
            stimulus    <= (carrier_nxt < CarHalf);
          end
        end
      end
    end
  end

  tick_div #(
    .DIV(SCAN_DIV)
  ) u_scan_div (
    .system_clk(system_clk),
    .reset     (reset),
    .clear     (1'b0),
    .tick      (tick_scan)
  );

`ifdef ULTRA_FRAC_CM_EN
  logic [31:0] cm_acc_q;
  logic [32:0] cm_sum;
  logic        unused_cfg;

  assign cm_sum     = {1'b0, cm_acc_q} + 33'(CM_INC);
  assign unused_cfg = ^CM_DIV;

  always_ff @(posedge system_clk) begin
    if (reset || cm_clear) begin
      cm_acc_q <= '0;
      tick_cm  <= 1'b0;
    end else begin
      cm_acc_q <= cm_sum[31:0];
      tick_cm  <= cm_sum[32];
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^CM_INC;

  tick_div #(
    .DIV(CM_DIV)
  ) u_cm_div (
    .system_clk(system_clk),
    .reset     (reset),
    .clear     (cm_clear),
    .tick      (tick_cm)
  );
`endif

endmodule

// File: tb/tb_ultra_timebase.sv
// Randomised scoreboard bench for ultra_timebase against a frame-timeline reference model.
module tb_ultra_timebase;

  localparam int CD  = 4;
  localparam int BP  = 3;
  localparam int FC  = 40;
  localparam int SD  = 5;
  localparam int CMD = 7;
  localparam int unsigned CMI = 32'd536870912;
  localparam int BL  = CD * BP;

  logic system_clk = 1'b0;
  logic reset, mode, trig, abort;
  logic stimulus, burst_active, listening, frame_start, frame_done, tick_scan, tick_cm;

  ultra_timebase #(
    .CARRIER_DIV (CD),
    .BURST_PULSES(BP),
    .FRAME_CYCLES(FC),
    .SCAN_DIV    (SD),
    .CM_DIV      (CMD),
    .CM_INC      (CMI)
  ) dut (
    .system_clk  (system_clk),
    .reset       (reset),
    .mode        (mode),
    .trig        (trig),
    .abort       (abort),
    .stimulus    (stimulus),
    .burst_active(burst_active),
    .listening   (listening),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .tick_scan   (tick_scan),
    .tick_cm     (tick_cm)
  );

  always #5 system_clk = ~system_clk;

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  // Reference model: a frame is just "the cycle it started"; everything follows from the phase.
  int cyc       = 0;
  bit in_frame  = 1'b0;
  int fs        = 0;
  int scan_base = 0;

  function automatic bit cm_tick(input int k);
`ifdef ULTRA_FRAC_CM_EN
    longint unsigned a, b;
    if (k < 1) return 1'b0;
    a = longint'(k) * longint'(CMI);
    b = longint'(k - 1) * longint'(CMI);
    return (a >> 32) != (b >> 32);
`else
    return (k >= 1) && (k % CMD == 0);
`endif
  endfunction

  task automatic drive(input bit r, input bit m, input bit t, input bit a);
    exp_t e;
    int   p;
    bit   end_now;
    reset = r;
    mode  = m;
    trig  = t;
    abort = a;
    end_now = in_frame && (cyc - fs == FC - 1);
    if (r) begin
      in_frame  = 1'b0;
      scan_base = cyc + 1;
    end else if (a) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (m || t) begin
        in_frame = 1'b1;
        fs       = cyc + 1;
      end
    end else if (end_now) begin
      if (m) fs = cyc + 1;
      else in_frame = 1'b0;
    end
    cyc++;
    p = cyc - fs;
    e.cyc = cyc;
    e.v = {in_frame && (p < BL) && ((p % CD) < CD / 2),
           in_frame && (p < BL),
           in_frame && (p >= BL),
           in_frame && (p == 0),
           in_frame && (p == FC - 1),
           ((cyc - scan_base) > 0) && ((cyc - scan_base) % SD == 0),
           in_frame && cm_tick(p)};
    sb.push_back(e);
    @(posedge system_clk);
    #1;
  endtask

  initial begin : monitor
    exp_t       me;
    logic [6:0] got;
    forever begin
      @(negedge system_clk);
      if (sb.size() > 0) begin
        me  = sb.pop_front();
        got = {stimulus, burst_active, listening, frame_start, frame_done, tick_scan, tick_cm};
        total++;
        if (got !== me.v) begin
          bad++;
          $display("FAIL outputs cyc=%0d {stim,burst,listen,fstart,fdone,tscan,tcm} got=%b exp=%b",
                   me.cyc, got, me.v);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge system_clk);
    if (!done) begin
      bad++;
      $display("FAIL timeout: stimulus sequence did not complete within 20000 cycles");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin : stim
    bit         rm;
    logic [6:0] rst_out;
    reset = 1'b1;
    mode  = 1'b0;
    trig  = 1'b0;
    abort = 1'b0;
    repeat (3) drive(1, 0, 0, 0);
    rst_out = {stimulus, burst_active, listening, frame_start, frame_done, tick_scan, tick_cm};
    total++;
    if (rst_out !== 7'b0) begin
      bad++;
      $display("FAIL reset state: outputs=%b exp=0000000", rst_out);
    end
    repeat (9) drive(0, 0, 0, 0);
    // Single-shot frame, run through to frame_done and back to idle.
    drive(0, 0, 1, 0);
    repeat (50) drive(0, 0, 0, 0);
    // Abort mid-burst, then trig and abort together.
    drive(0, 0, 1, 0);
    repeat (4) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    repeat (5) drive(0, 0, 0, 0);
    drive(0, 0, 1, 1);
    repeat (5) drive(0, 0, 0, 0);
    // Trigs inside a running frame must be ignored.
    drive(0, 0, 1, 0);
    repeat (20) drive(0, 0, bit'($urandom_range(0, 1)), 0);
    repeat (30) drive(0, 0, 0, 0);
    // Continuous frames back to back.
    repeat (130) drive(0, 1, 0, 0);
    // Reset while listening.
    for (int i = 0; i < FC && !(in_frame && (cyc - fs == BL + 3)); i++) drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    repeat (12) drive(0, 0, 0, 0);
    // Random soak.
    rm = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) rm = !rm;
      drive($urandom_range(0, 299) == 0, rm, $urandom_range(0, 9) == 0,
            $urandom_range(0, 59) == 0);
    end
    repeat (2) @(negedge system_clk);
    #1;
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
